multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max consecutive stall cycles in a memory state before abort; 0 = never abort.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction opcode from instruction register.
REQ-005 mem_ready  input  1  memory completes current access this cycle.
REQ-006 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-007 alu_src_b  output  2  00 = B, 01 = constant 1, 10/11 = zero-extended immediate.
REQ-008 alu_op  output  2  00 = add, 01 = subtract, 10 = funct decode.
REQ-009 pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 i_or_d, mem_read, mem_write, ir_write  output  1 each  memory/IR controls.
REQ-011 reg_dst, mem_to_reg, reg_write  output  1 each  register-file controls.
REQ-012 pc_write, pc_write_cond  output  1 each  unconditional / branch PC update.
REQ-013 mem_err  output  1  one-cycle pulse on memory timeout abort.
REQ-014 illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-015 The state register SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB; the controller advances at most one state per clock.
REQ-016 Control outputs SHALL be decoded from the current state only (Moore); ir_write and pc_write in FETCH are additionally ANDed with mem_ready; unlisted outputs are 0.
REQ-017 FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; advance to DECODE on mem_ready.
REQ-018 DECODE: alu_src_b=11, alu_op=00; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX, other -> FETCH with illegal_op=1 next cycle.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10; next MEMRD if opcode 100011, else MEMWR.
REQ-020 MEMRD: mem_read=1, i_or_d=1; -> MEMWB on mem_ready. MEMWB: reg_write=1, mem_to_reg=1; -> FETCH.
REQ-021 MEMWR: mem_write=1, i_or_d=1; -> FETCH on mem_ready.
REQ-022 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> ALUWB. ALUWB: reg_write=1, reg_dst=1; -> FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; -> FETCH. JUMP: pc_write=1, pc_source=10; -> FETCH.
REQ-024 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; -> ADDIWB. ADDIWB: reg_write=1; -> FETCH.
REQ-025 In FETCH, MEMRD, MEMWR with mem_ready=0 the state SHALL hold and a stall counter increments; counter clears on any state change.
REQ-026 When MEM_TIMEOUT>0 and the stall counter equals MEM_TIMEOUT with mem_ready=0, next state SHALL be FETCH and mem_err pulses one cycle; mem_ready=1 in that same cycle wins (normal advance, no mem_err).
REQ-027 Stall counter SHALL saturate and be wide enough for MEM_TIMEOUT; with MEM_TIMEOUT=0 mem_err never asserts.

Reset
REQ-028 reset high SHALL immediately force state=FETCH, stall counter=0, all outputs 0 (incl. mem_read, mem_err, illegal_op), overriding Moore decode, even mid-instruction.
REQ-029 First rising edge after reset release SHALL evaluate FETCH normally.

Configuration
REQ-030 Macro MC_PERF_CNT_EN defined: extra outputs instr_count (32-bit, +1 on each transition into FETCH from a completing state, excluding timeout/illegal aborts) and cycle_count (32-bit, +1 every clock), both wrapping at 2^32, reset to 0.
REQ-031 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset mid-MEMRD -> outputs all 0 while reset high; FETCH outputs one cycle after release.
REQ-033 R-type (000000), mem_ready=1 always -> FETCH,DECODE,EXEC,ALUWB,FETCH; reg_dst=reg_write=1 only in ALUWB; 4 cycles.
REQ-034 lw (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1; total 8 cycles.
REQ-035 MEM_TIMEOUT=2, mem_ready stuck 0 in MEMWR -> FETCH after 3 MEMWR cycles, mem_err one pulse, no mem_write after abort.
REQ-036 Opcode 111111 -> DECODE then FETCH, illegal_op one pulse; beq (000100) -> pc_write_cond=1, alu_op=01 in BRANCH only.
REQ-037 MC_PERF_CNT_EN: three R-types -> instr_count=3; preset cycle_count 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control unit for a multicycle MIPS-style datapath with memory-stall timeout.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       mem_err,
    output logic       illegal_op
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
`endif
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam int         CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] stall_q, stall_d;
    logic          memErr_q, memErr_d;
    logic          illegal_q, illegal_d;
    logic          memWait;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            stall_q   <= '0;
            memErr_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            memErr_q  <= memErr_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        memWait   = 1'b0;
        memErr_d  = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            FETCH: begin
                memWait = 1'b1;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = MEMADR;
                else if (opcode == OP_RTYPE)            state_d = EXEC;
                else if (opcode == OP_BEQ)              state_d = BRANCH;
                else if (opcode == OP_J)                state_d = JUMP;
                else if (opcode == OP_ADDI)             state_d = ADDIEX;
                else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                memWait = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWR: begin
                memWait = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXEC:    state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase

        // A late mem_ready on the timeout cycle still completes the access normally
        if (MEM_TIMEOUT > 0 && memWait && !mem_ready && stall_q == CW'(MEM_TIMEOUT)) begin
            state_d  = FETCH;
            memErr_d = 1'b1;
        end

        if (memErr_d || state_d != state_q)      stall_d = '0;
        else if (memWait && stall_q != '1)       stall_d = stall_q + CW'(1);
        else                                     stall_d = stall_q;
    end

    always_comb begin
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE:  alu_src_b = 2'b11;
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDIWB:  reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_err    = memErr_q;
    assign illegal_op = illegal_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] instrCnt_q, cycleCnt_q;
    logic        completing;

    // Aborts also land in FETCH, so they are excluded from the retired-instruction count
    assign completing = (state_d == FETCH) && (state_q != FETCH) && !memErr_d && !illegal_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instrCnt_q <= '0;
            cycleCnt_q <= '0;
        end else begin
            cycleCnt_q <= cycleCnt_q + 32'd1;
            if (completing) instrCnt_q <= instrCnt_q + 32'd1;
        end
    end

    assign instr_count = instrCnt_q;
    assign cycle_count = cycleCnt_q;
`endif

endmodule
